// File: rtl/bias_add_requant_19_pkg.sv
// Shared layer-19 sizes and the LOAD/RUN state encoding for the bias/requant stage.
package bias_add_requant_19_pkg;

    localparam int unsigned coeff_width  = 16;
    localparam int unsigned acc_width_19 = 32;
    localparam int unsigned out_width_19 = 16;
    localparam int unsigned kern_s_k_19  = 16;
    localparam int unsigned n_pix_19     = 64;
    localparam int unsigned shift_19     = 8;
    localparam int unsigned relu_en_19   = 1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/requant_sat.sv
// Bias add, optional ReLU, round-half-up arithmetic right shift and signed saturation.
module requant_sat #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT   = 8,
    parameter int unsigned RELU_EN = 1
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [COEFF_W-1:0] bias,
    output logic [OUT_W-1:0]   res_c
);

    // Two guard bits: one for the bias add, one for the rounding constant.
    localparam int unsigned RW = ACC_W + 2;
    localparam logic signed [RW-1:0] RND   = (RW'(1) << SHIFT) >> 1;
    localparam logic signed [RW-1:0] MAX_V = RW'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [RW-1:0] MIN_V = ~MAX_V;

    logic signed [RW-1:0] sum;
    logic signed [RW-1:0] act;
    logic signed [RW-1:0] rnd;

    always_comb begin
        sum = {{(RW - ACC_W){acc[ACC_W-1]}}, acc}
            + {{(RW - COEFF_W){bias[COEFF_W-1]}}, bias};
        act = sum;
        if ((RELU_EN != 0) && sum[RW-1]) begin
            act = '0;
        end
        rnd = (act + RND) >>> SHIFT;
        if (rnd > MAX_V) begin
            res_c = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (rnd < MIN_V) begin
            res_c = {1'b1, {(OUT_W - 1){1'b0}}};
        end else begin
            res_c = rnd[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/bias_add_requant_19.sv
// Layer-19 consumer: buffers per-frame biases, then bias-adds and requantises the
// accumulator stream onto an ap_fifo output with a single output register.
module bias_add_requant_19
    import bias_add_requant_19_pkg::*;
#(
    parameter int unsigned COEFF_W = coeff_width,
    parameter int unsigned ACC_W   = acc_width_19,
    parameter int unsigned OUT_W   = out_width_19,
    parameter int unsigned N_CH    = kern_s_k_19,
    parameter int unsigned N_PIX   = n_pix_19,
    parameter int unsigned SHIFT   = shift_19,
    parameter int unsigned RELU_EN = relu_en_19
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [COEFF_W-1:0] bias_V_dout,
    input  logic               bias_V_empty_n,
    output logic               bias_V_read,
    input  logic [ACC_W-1:0]   input_V_dout,
    input  logic               input_V_empty_n,
    output logic               input_V_read,
    output logic [OUT_W-1:0]   output_V_din,
    input  logic               output_V_full_n,
    output logic               output_V_write
);

    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_PIX - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CH_W-1:0]    ch_cnt;
    logic [PIX_W-1:0]   pix_cnt;
    logic               out_vld;
    logic [COEFF_W-1:0] bias_buf [N_CH];
    logic [OUT_W-1:0]   res_c;
    logic               ch_last;
    logic               pix_last;

    assign ch_last  = (ch_cnt == CH_LAST);
    assign pix_last = (pix_cnt == PIX_LAST);

    requant_sat #(
        .ACC_W   (ACC_W),
        .COEFF_W (COEFF_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .RELU_EN (RELU_EN)
    ) u_requant (
        .acc   (input_V_dout),
        .bias  (bias_buf[ch_cnt]),
        .res_c (res_c)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (bias_V_read && ch_last) state_nxt = ST_RUN;
            ST_RUN:  if (input_V_read && ch_last && pix_last) state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Stream strobes; all held low while reset is asserted.
    always_comb begin
        bias_V_read    = 1'b0;
        input_V_read   = 1'b0;
        output_V_write = ap_rst_n & out_vld & output_V_full_n;
        if (ap_rst_n) begin
            case (state)
                ST_LOAD: bias_V_read  = bias_V_empty_n;
                ST_RUN:  input_V_read = input_V_empty_n & (~out_vld | output_V_full_n);
                default: ;
            endcase
        end
    end

    // One channel counter serves both bias loading and accumulator consumption.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            ch_cnt       <= '0;
            pix_cnt      <= '0;
            out_vld      <= 1'b0;
            output_V_din <= '0;
        end else begin
            if (bias_V_read || input_V_read) begin
                ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
            end
            if (input_V_read && ch_last) begin
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
            end
            if (input_V_read) begin
                output_V_din <= res_c;
                out_vld      <= 1'b1;
            end else if (output_V_write) begin
                out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (bias_V_read) begin
            bias_buf[ch_cnt] <= bias_V_dout;
        end
    end

endmodule

// File: tb/tb_bias_add_requant_19.sv
// Directed bench for bias_add_requant_19: arithmetic vector table plus stream-level sequences.
module tb_bias_add_requant_19;

    localparam int unsigned COEFF_W = 16;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned N_CH    = 4;
    localparam int unsigned N_PIX   = 2;
    localparam int unsigned SHIFT   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [COEFF_W-1:0] bias_dout;
    logic               bias_empty_n;
    logic               bias_rd;
    logic [ACC_W-1:0]   in_dout;
    logic               in_empty_n;
    logic               in_rd;
    logic [OUT_W-1:0]   out_din;
    logic               out_full_n;
    logic               out_wr;

    logic [ACC_W-1:0]   v_acc;
    logic [COEFF_W-1:0] v_bias;
    logic [OUT_W-1:0]   f_relu;
    logic [OUT_W-1:0]   f_lin;

    always #5 clk = ~clk;

    bias_add_requant_19 #(
        .COEFF_W (COEFF_W), .ACC_W (ACC_W), .OUT_W (OUT_W),
        .N_CH (N_CH), .N_PIX (N_PIX), .SHIFT (SHIFT), .RELU_EN (1)
    ) dut (
        .ap_clk          (clk),
        .ap_rst_n        (rst_n),
        .bias_V_dout     (bias_dout),
        .bias_V_empty_n  (bias_empty_n),
        .bias_V_read     (bias_rd),
        .input_V_dout    (in_dout),
        .input_V_empty_n (in_empty_n),
        .input_V_read    (in_rd),
        .output_V_din    (out_din),
        .output_V_full_n (out_full_n),
        .output_V_write  (out_wr)
    );

    requant_sat #(.ACC_W(ACC_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU_EN(1))
        u_f_relu (.acc(v_acc), .bias(v_bias), .res_c(f_relu));
    requant_sat #(.ACC_W(ACC_W), .COEFF_W(COEFF_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .RELU_EN(0))
        u_f_lin (.acc(v_acc), .bias(v_bias), .res_c(f_lin));

    typedef struct {
        logic [ACC_W-1:0]   acc;
        logic [COEFF_W-1:0] bias;
        int                 exp_relu;
        int                 exp_lin;
    } vec_t;

    logic [COEFF_W-1:0] bias_q [$];
    logic [ACC_W-1:0]   acc_q  [$];
    int                 exp_q  [$];

    int checks = 0;
    int errors = 0;
    int n_bpop = 0;
    int n_ipop = 0;
    int n_wr   = 0;
    logic s_brd, s_ird, s_wr;
    logic [OUT_W-1:0] s_din;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic refresh();
        bias_empty_n = (bias_q.size() != 0);
        bias_dout    = bias_empty_n ? bias_q[0] : COEFF_W'($urandom);
        in_empty_n   = (acc_q.size() != 0);
        in_dout      = in_empty_n ? acc_q[0] : ACC_W'($urandom);
    endtask

    // Sample strobes mid-cycle, then retire the FIFO entries they consumed after the edge.
    task automatic tick();
        int e;
        @(negedge clk);
        s_brd = bias_rd;
        s_ird = in_rd;
        s_wr  = out_wr;
        s_din = out_din;
        if (s_wr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write actual=%0d required=no_write", $signed(s_din));
            end else begin
                e = exp_q.pop_front();
                check("out_value", $signed(s_din), e);
            end
        end
        if (s_brd) n_bpop++;
        if (s_ird) n_ipop++;
        @(posedge clk);
        #1;
        if (s_brd) void'(bias_q.pop_front());
        if (s_ird) void'(acc_q.pop_front());
        refresh();
    endtask

    task automatic run_writes(input string name, input int target, input int budget);
        int k = 0;
        while (n_wr < target && k < budget) begin
            tick();
            k++;
        end
        check(name, n_wr, target);
    endtask

    task automatic push_bias(input int b0, input int b1, input int b2, input int b3);
        bias_q.push_back(COEFF_W'(b0));
        bias_q.push_back(COEFF_W'(b1));
        bias_q.push_back(COEFF_W'(b2));
        bias_q.push_back(COEFF_W'(b3));
    endtask

    task automatic push_exp(input int e0, input int e1, input int e2, input int e3);
        for (int p = 0; p < int'(N_PIX); p++) begin
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            exp_q.push_back(e3);
        end
    endtask

    initial begin
        vec_t vecs [12];
        int base_w, base_i, base_b, acc_reads, k, held;

        vecs[0]  = '{32'h7FFFFF80, 16'h7FFF, 32767, 32767};
        vecs[1]  = '{-32'sd300000000, 16'h0000, 0, -32768};
        vecs[2]  = '{32'd127, 16'h0000, 0, 0};
        vecs[3]  = '{32'd128, 16'h0000, 1, 1};
        vecs[4]  = '{-32'sd129, 16'h0000, 0, -1};
        vecs[5]  = '{-32'sd128, 16'h0000, 0, 0};
        vecs[6]  = '{-32'sd8388737, 16'h0000, 0, -32768};
        vecs[7]  = '{-32'sd8388480, 16'h0000, 0, -32767};
        vecs[8]  = '{32'd1000, -16'sd2000, 0, -4};
        vecs[9]  = '{32'h7FFFFFFF, 16'h7FFF, 32767, 32767};
        vecs[10] = '{32'h80000000, 16'h8000, 0, -32768};
        vecs[11] = '{32'd8388224, 16'h0000, 32767, 32767};

        for (int i = 0; i < 12; i++) begin
            v_acc  = vecs[i].acc;
            v_bias = vecs[i].bias;
            #1;
            check("vec_relu", $signed(f_relu), vecs[i].exp_relu);
            check("vec_lin", $signed(f_lin), vecs[i].exp_lin);
        end

        // Reset with bias data waiting: no strobes may fire.
        rst_n      = 1'b0;
        out_full_n = 1'b1;
        push_bias(7, 7, 7, 7);
        refresh();
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_bias_read", s_brd, 0);
            check("rst_input_read", s_ird, 0);
            check("rst_write", s_wr, 0);
            check("rst_din", s_din, 0);
        end
        bias_q.delete();
        refresh();
        rst_n = 1'b1;

        // Two back-to-back frames with different bias sets, no backpressure.
        push_bias(256, -512, 0, 1024);
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd512);
        push_bias(-256, 512, 128, 0);
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd512);
        push_exp(3, 0, 2, 6);
        push_exp(1, 4, 3, 2);
        refresh();
        k = 0;
        s_ird = 1'b0;
        while (!s_ird && k < 20) begin
            tick();
            k++;
        end
        check("first_pop_seen", s_ird, 1);
        check("biases_before_first_pop", n_bpop, 4);
        tick();
        check("first_out_latency", s_wr, 1);
        k = 0;
        while (n_ipop < 8 && k < 20) begin
            tick();
            k++;
        end
        check("frame1_pops", n_ipop, 8);
        tick();
        check("load_after_last_pop_bias_read", s_brd, 1);
        check("load_after_last_pop_input_read", s_ird, 0);
        run_writes("frames_12_writes", 16, 40);
        check("frames_12_pops", n_ipop, 16);

        // Backpressure for 5 cycles mid-frame.
        base_w = n_wr;
        base_i = n_ipop;
        push_bias(256, -512, 0, 1024);
        for (int i = 0; i < 8; i++) acc_q.push_back(ACC_W'(256 * (i + 1)));
        exp_q.push_back(2);  exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(8);
        exp_q.push_back(6);  exp_q.push_back(4); exp_q.push_back(7); exp_q.push_back(12);
        refresh();
        run_writes("bp_pre_writes", base_w + 3, 30);
        out_full_n = 1'b0;
        acc_reads = 0;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) held = $signed(s_din);
            acc_reads += int'(s_ird);
            check("bp_write", s_wr, 0);
            check("bp_din_stable", $signed(s_din), 8);
        end
        check("bp_pops", acc_reads, 0);
        check("bp_held_value", held, 8);
        out_full_n = 1'b1;
        run_writes("bp_writes", base_w + 8, 30);
        for (int i = 0; i < 3; i++) tick();
        check("bp_total_writes", n_wr, base_w + 8);
        check("bp_total_pops", n_ipop, base_i + 8);

        // Bias stream stalls after 2 of 4 with accumulators waiting.
        base_w = n_wr;
        base_b = n_bpop;
        bias_q.push_back(COEFF_W'(512));
        bias_q.push_back(COEFF_W'(256));
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd256);
        push_exp(3, 2, 0, 1);
        refresh();
        acc_reads = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            acc_reads += int'(s_ird);
        end
        check("stall_input_reads", acc_reads, 0);
        check("stall_bias_pops", n_bpop, base_b + 2);
        bias_q.push_back(-COEFF_W'(256));
        bias_q.push_back(COEFF_W'(0));
        refresh();
        run_writes("stall_writes", base_w + 8, 40);

        // Reset after 5 pops of a frame.
        base_w = n_wr;
        base_i = n_ipop;
        push_bias(256, -512, 0, 1024);
        for (int i = 0; i < 8; i++) acc_q.push_back(32'd512);
        push_exp(3, 0, 2, 6);
        refresh();
        k = 0;
        while (n_ipop - base_i < 5 && k < 30) begin
            tick();
            k++;
        end
        check("pops_before_reset", n_ipop - base_i, 5);
        check("writes_before_reset", n_wr - base_w, 4);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_input_read", s_ird, 0);
        check("midrst_write", s_wr, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_din", s_din, 0);
        check("post_rst_write", s_wr, 0);
        check("post_rst_input_read", s_ird, 0);
        acc_reads = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            acc_reads += int'(s_ird);
        end
        check("post_rst_no_input_reads", acc_reads, 0);
        base_w = n_wr;
        base_b = n_bpop;
        push_bias(-256, 512, 128, 0);
        for (int i = 0; i < 5; i++) acc_q.push_back(32'd512);
        push_exp(1, 4, 3, 2);
        refresh();
        k = 0;
        s_ird = 1'b0;
        while (!s_ird && k < 20) begin
            tick();
            k++;
        end
        check("reload_biases_before_pop", n_bpop - base_b, 4);
        run_writes("post_rst_writes", base_w + 8, 40);
        for (int i = 0; i < 3; i++) tick();
        check("final_acc_left", acc_q.size(), 0);
        check("final_exp_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
